text_buffer_arbiter: RTL and testbench

- Parametrised multi-client text buffer: N writer clients compete for a shared dual-port text RAM through a registered round-robin arbiter.
- An internal streamer reads the buffer out one character per Clk_Ena as a NUL-terminated, wrapping character stream.
- Replaces the fixed 6-client, fixed-priority, 1 kB text block in the transmitter text path; feeds the S/PDIF user-data / display formatter.

---
 rtl/text_buffer_arbiter_if.sv | 15 +
 rtl/text_buffer_arbiter.sv | 165 ++++++++++++++++
 tb/tb_text_buffer_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buffer_arbiter_if.sv
// Writer-client bus for text_buffer_arbiter: per-client request/write payloads and the registered grant.
interface text_buffer_arbiter_if #(
  parameter int unsigned N_CLIENTS  = 6,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [N_CLIENTS-1:0]            Request;
  logic [N_CLIENTS-1:0]            Grant;
  logic [N_CLIENTS*ADDR_WIDTH-1:0] Address;
  logic [N_CLIENTS*DATA_WIDTH-1:0] Data;
  logic [N_CLIENTS-1:0]            Write_Enable;

  modport master (output Request, Address, Data, Write_Enable, input Grant);
  modport slave  (input Request, Address, Data, Write_Enable, output Grant);
endinterface

// File: rtl/text_buffer_arbiter.sv
// Round-robin multi-writer text buffer with a NUL-terminated, wrapping character streamer.
// Optional macro TEXT_BUFFER_WRITE_ERROR_EN adds sticky per-client Write_Error flags.
module text_buffer_arbiter #(
  parameter int unsigned            N_CLIENTS  = 6,
  parameter int unsigned            ADDR_WIDTH = 10,
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  TERMINATOR = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Clk_Ena,
  text_buffer_arbiter_if.slave  bus,
  output logic [DATA_WIDTH-1:0] Stream,
  output logic                  Frame_Start
`ifdef TEXT_BUFFER_WRITE_ERROR_EN
  ,
  output logic [N_CLIENTS-1:0]  Write_Error
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(N_CLIENTS);

  typedef enum logic {ST_PRIME, ST_READY} state_t;

  logic [N_CLIENTS-1:0]  r_grant;
  logic [N_CLIENTS-1:0]  w_grant_nxt;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic                  w_hold;
  logic                  w_found;

  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
  logic [DATA_WIDTH-1:0] r_stream;
  logic [DATA_WIDTH-1:0] w_stream_nxt;
  logic                  r_frame_start;
  logic                  w_frame_start_nxt;

  // Grant is one-hot, so any overlap with Request means the owner still wants the bus.
  assign w_hold = |(r_grant & bus.Request);

  // Round-robin search starting just after the last granted client.
  always_comb begin
    w_grant_nxt = '0;
    w_ptr_nxt   = r_ptr;
    w_found     = 1'b0;
    if (w_hold) begin
      w_grant_nxt = r_grant;
    end else begin
      for (int unsigned k = 1; k <= N_CLIENTS; k++) begin
        if (!w_found && bus.Request[(32'(r_ptr) + k) % N_CLIENTS]) begin
          w_found                                         = 1'b1;
          w_grant_nxt[(32'(r_ptr) + k) % N_CLIENTS]       = 1'b1;
          w_ptr_nxt                                       = PTR_W'((32'(r_ptr) + k) % N_CLIENTS);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_grant <= '0;
      r_ptr   <= PTR_W'(N_CLIENTS - 1);
    end else begin
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.Grant = r_grant;

  // Only the current owner's slice can reach the RAM write port.
  always_comb begin
    w_wr_en   = |(r_grant & bus.Write_Enable);
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (r_grant[i]) begin
        w_wr_addr = bus.Address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wr_data = bus.Data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Simple dual-port RAM; the read port sees pre-write contents on an address collision.
  always_ff @(posedge Clk) begin
    if (w_wr_en && !Reset) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
    r_rd_data <= r_mem[r_rd_addr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rd_addr_nxt     = r_rd_addr;
    w_stream_nxt      = r_stream;
    w_frame_start_nxt = 1'b0;
    case (r_state)
      ST_PRIME: begin
        w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (Clk_Ena) begin
          w_stream_nxt      = r_rd_data;
          w_frame_start_nxt = (r_rd_addr == '0);
          if (r_rd_data == TERMINATOR || r_rd_addr == '1) begin
            w_rd_addr_nxt = '0;
          end else begin
            w_rd_addr_nxt = r_rd_addr + ADDR_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd_addr     <= '0;
      r_stream      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_rd_addr     <= w_rd_addr_nxt;
      r_stream      <= w_stream_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign Stream      = r_stream;
  assign Frame_Start = r_frame_start;

`ifdef TEXT_BUFFER_WRITE_ERROR_EN
  logic [N_CLIENTS-1:0] r_write_error;

  // Set by an ungranted write, cleared when the client requests without writing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_write_error <= '0;
    end else begin
      r_write_error <= (r_write_error | (bus.Write_Enable & ~r_grant))
                       & ~(bus.Request & ~bus.Write_Enable);
    end
  end

  assign Write_Error = r_write_error;
`endif

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Self-checking bench for text_buffer_arbiter: behavioural model compared every cycle plus directed literals.
module tb_text_buffer_arbiter;
  localparam int unsigned N     = 6;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [DW-1:0] stream;
  logic          fs;
`ifdef TEXT_BUFFER_WRITE_ERROR_EN
  logic [N-1:0]  werr;
`endif

  text_buffer_arbiter_if #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  text_buffer_arbiter #(
    .N_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TERMINATOR(8'h00)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .Clk_Ena(ena),
    .bus(bus),
    .Stream(stream),
    .Frame_Start(fs)
`ifdef TEXT_BUFFER_WRITE_ERROR_EN
    ,
    .Write_Error(werr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot(input int i);
    return (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Behavioural model: owner index, last winner, text memory, and stream cursor.
  int          m_gidx;
  int          m_last;
  int          m_addr;
  logic [7:0]  m_stream;
  logic        m_fs;
  logic        m_prime;
  logic        m_valid = 1'b0;
  logic [7:0]  m_mem [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      m_gidx = -1; m_last = N - 1; m_addr = 0;
      m_stream = 8'h00; m_fs = 1'b0; m_prime = 1'b1; m_valid = 1'b1;
    end else if (m_valid) begin
      logic       wr;
      int         wa;
      logic [7:0] wd;
      wr = 1'b0; wa = 0; wd = 8'h00;
      if (m_gidx >= 0 && bus.Write_Enable[m_gidx]) begin
        wr = 1'b1;
        wa = int'(bus.Address[m_gidx*AW +: AW]);
        wd = bus.Data[m_gidx*DW +: DW];
      end
      m_fs = 1'b0;
      if (m_prime) begin
        m_prime = 1'b0;
      end else if (ena) begin
        m_stream = m_mem[m_addr];
        m_fs     = (m_addr == 0);
        m_addr   = (m_mem[m_addr] == 8'h00 || m_addr == DEPTH - 1) ? 0 : m_addr + 1;
      end
      if (wr) m_mem[wa] = wd;
      if (!(m_gidx >= 0 && bus.Request[m_gidx])) begin
        m_gidx = -1;
        for (int k = 1; k <= N; k++) begin
          if (m_gidx < 0 && bus.Request[(m_last + k) % N]) begin
            m_gidx = (m_last + k) % N;
            m_last = m_gidx;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_grant", 32'(bus.Grant), onehot(m_gidx));
      chk("model_stream", 32'(stream), 32'(m_stream));
      chk("model_frame_start", 32'(fs), 32'(m_fs));
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int idx);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.Grant == N'(onehot(idx))) ok = 1'b1;
    end
    chk("wait_grant", 32'(ok), 32'd1);
  endtask

  task automatic write(input int i, input int a, input logic [7:0] d);
    bus.Write_Enable           = '0;
    bus.Write_Enable[i]        = 1'b1;
    bus.Address[i*AW +: AW]    = AW'(a);
    bus.Data[i*DW +: DW]       = d;
    @(negedge clk);
  endtask

  task automatic strobe(input int gap, output logic [7:0] s, output logic f);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    s = stream;
    f = fs;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    logic       f;
    int         g;

    bus.Request = '0; bus.Write_Enable = '0; bus.Address = '0; bus.Data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_grant", 32'(bus.Grant), 32'd0);
    chk("reset_stream", 32'(stream), 32'd0);
    chk("reset_frame_start", 32'(fs), 32'd0);

    // Basic grant, zero-idle handover, release
    bus.Request = 6'b000101; @(negedge clk);
    chk("t1_first_grant", 32'(bus.Grant), 32'h01);
    bus.Request = 6'b000100; @(negedge clk);
    chk("t1_handover", 32'(bus.Grant), 32'h04);
    bus.Request = 6'b000000; @(negedge clk);
    chk("t1_release", 32'(bus.Grant), 32'h00);

    // Round-robin fairness with all clients requesting
    do_reset();
    bus.Request = '1;
    for (int n = 0; n < 7; n++) begin
      g = -1;
      for (int c = 0; c < 20 && g < 0; c++) begin
        @(negedge clk);
        g = idx_of(bus.Grant);
      end
      chk("t2_rr_order", 32'(g), 32'(n % 6));
      if (g >= 0) begin
        repeat (3) @(negedge clk);
        bus.Request[g] = 1'b0;
        @(negedge clk);
        bus.Request[g] = 1'b1;
      end
    end
    bus.Request = '0; @(negedge clk);

    // "HI" frame with terminator
    bus.Request = 6'b001000; wait_grant(3);
    write(3, 0, 8'h48); write(3, 1, 8'h49); write(3, 2, 8'h00);
    bus.Write_Enable = '0; bus.Request = '0;
    do_reset();
    strobe(4, s, f); chk("t3_s0", 32'(s), 32'h48); chk("t3_f0", 32'(f), 32'd1);
    strobe(4, s, f); chk("t3_s1", 32'(s), 32'h49); chk("t3_f1", 32'(f), 32'd0);
    strobe(4, s, f); chk("t3_s2", 32'(s), 32'h00); chk("t3_f2", 32'(f), 32'd0);
    strobe(4, s, f); chk("t3_s3", 32'(s), 32'h48); chk("t3_f3", 32'(f), 32'd1);

    // Full buffer without terminator wraps at the last address
    bus.Request = 6'b000001; wait_grant(0);
    for (int a = 0; a < DEPTH; a++) write(0, a, 8'((a % 255) + 1));
    bus.Write_Enable = '0; bus.Request = '0;
    do_reset();
    for (int n = 1; n <= DEPTH + 1; n++) begin
      strobe(2, s, f);
      if (n == 1) begin
        chk("t4_first_s", 32'(s), 32'h01); chk("t4_first_f", 32'(f), 32'd1);
      end
      if (n == DEPTH) begin
        chk("t4_last_s", 32'(s), 32'h04); chk("t4_last_f", 32'(f), 32'd0);
      end
      if (n == DEPTH + 1) begin
        chk("t4_wrap_s", 32'(s), 32'h01); chk("t4_wrap_f", 32'(f), 32'd1);
      end
    end

    // Ungranted write from client 1 while client 2 owns the bus
    bus.Request = 6'b000100; wait_grant(2);
    bus.Write_Enable[1] = 1'b1; bus.Address[1*AW +: AW] = AW'(5); bus.Data[1*DW +: DW] = 8'h41;
    @(negedge clk);
    chk("t5_grant_kept", 32'(bus.Grant), 32'h04);
`ifdef TEXT_BUFFER_WRITE_ERROR_EN
    chk("t5_write_error", 32'(werr), 32'h02);
`endif
    bus.Write_Enable = '0; bus.Request = '0;
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      strobe(2, s, f);
      if (n == 6) begin
        chk("t5_addr5_s", 32'(s), 32'h06); chk("t5_addr5_f", 32'(f), 32'd0);
      end
    end

    // Reset during a write burst and mid-stream
    bus.Request = 6'b000001; wait_grant(0);
    write(0, 0, 8'h61); write(0, 1, 8'h62);
    bus.Address[0 +: AW] = AW'(2); bus.Data[0 +: DW] = 8'h63; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.Write_Enable = '0; bus.Request = '0;
    chk("t6_grant", 32'(bus.Grant), 32'h00);
    chk("t6_stream", 32'(stream), 32'h00);
    chk("t6_frame_start", 32'(fs), 32'd0);
    @(negedge clk);
    strobe(2, s, f); chk("t6_s0", 32'(s), 32'h61); chk("t6_f0", 32'(f), 32'd1);
    strobe(2, s, f); chk("t6_s1", 32'(s), 32'h62); chk("t6_f1", 32'(f), 32'd0);
    strobe(2, s, f); chk("t6_s2", 32'(s), 32'h03); chk("t6_f2", 32'(f), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
